// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad scan controller.
//   KEY_W         width of a key code (one hex digit)
//   COL_PATTERN   one-cold column strobe per column index 0..3
//   KEY_MAP       hex code of each key, indexed [col][row]
//   frame_kind_t  classification of one complete scan frame
//   decode_row()  classifies one sampled (active-low) row word
// Optional feature macro used by the files importing this package:
//   KEYPAD_REPEAT_EN (auto-repeat of a held key).
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int KEY_W = 4;

  localparam logic [3:0] COL_PATTERN [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  localparam logic [KEY_W-1:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h4, 4'h7, 4'h0},
    '{4'h2, 4'h5, 4'h8, 4'hF},
    '{4'h3, 4'h6, 4'h9, 4'hE},
    '{4'hA, 4'hB, 4'hC, 4'hD}
  };

  typedef enum logic [1:0] {
    FR_NONE  = 2'd0,
    FR_KEY   = 2'd1,
    FR_MULTI = 2'd2
  } frame_kind_t;

  // code is kept at zero unless kind is FR_KEY so whole-struct compares
  // are meaningful.
  typedef struct packed {
    frame_kind_t      kind;
    logic [KEY_W-1:0] code;
  } frame_result_t;

  typedef struct packed {
    logic       idle;     // no row active
    logic       single;   // exactly one row active
    logic [1:0] row_idx;  // which row, valid when single
  } slot_decode_t;

  // Rows are active low; row 0 is the MSB of the word.
  function automatic slot_decode_t decode_row(input logic [3:0] r);
    slot_decode_t d;
    d = '{idle: 1'b0, single: 1'b0, row_idx: 2'd0};
    case (r)
      4'b1111: d.idle = 1'b1;
      4'b0111: begin d.single = 1'b1; d.row_idx = 2'd0; end
      4'b1011: begin d.single = 1'b1; d.row_idx = 2'd1; end
      4'b1101: begin d.single = 1'b1; d.row_idx = 2'd2; end
      4'b1110: begin d.single = 1'b1; d.row_idx = 2'd3; end
      default: ;  // several rows low: multi-key
    endcase
    return d;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
// Frame-level debouncer. Takes one raw frame result per scan frame and keeps
// the debounced (stable) keypad state, raising a one-cycle event strobe when
// a new key becomes stable (and, with KEYPAD_REPEAT_EN defined, on
// auto-repeat while it stays stable).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   frame_valid   one-cycle strobe: frame_raw holds a new frame result
//   frame_raw     NONE / KEY(code) / MULTI for that frame
//   key_held      stable state is KEY
//   event_valid   one-cycle press (or repeat) event, aligned with the
//                 cycle in which the stable state is updated
//   event_code    code of the stable key (valid with event_valid)
// Macro: KEYPAD_REPEAT_EN adds REPEAT_DELAY / REPEAT_RATE (in frames).
// -----------------------------------------------------------------------------
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_valid,
  input  frame_result_t    frame_raw,
  output logic             key_held,
  output logic             event_valid,
  output logic [KEY_W-1:0] event_code
);

  localparam int MATCH_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(DEBOUNCE_FRAMES);
  localparam frame_result_t RESULT_NONE = '{kind: FR_NONE, code: '0};

  frame_result_t      prev_reg, prev_next;
  frame_result_t      stable_reg, stable_next;
  logic [MATCH_W-1:0] match_reg, match_next;
  logic               event_reg, event_next;

`ifdef KEYPAD_REPEAT_EN
  // Frames remaining until the next repeat event.
  logic [15:0] rep_reg, rep_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg   <= RESULT_NONE;
      stable_reg <= RESULT_NONE;
      match_reg  <= '0;
      event_reg  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_reg    <= '0;
`endif
    end else begin
      prev_reg   <= prev_next;
      stable_reg <= stable_next;
      match_reg  <= match_next;
      event_reg  <= event_next;
`ifdef KEYPAD_REPEAT_EN
      rep_reg    <= rep_next;
`endif
    end
  end

  always_comb begin
    prev_next   = prev_reg;
    stable_next = stable_reg;
    match_next  = match_reg;
    event_next  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_next    = rep_reg;
`endif
    if (frame_valid) begin
      // MULTI is remembered as the previous raw so that the first clean
      // frame after it starts a fresh run.
      prev_next = frame_raw;
      if (frame_raw.kind == FR_MULTI) begin
        match_next = '0;
      end else begin
        if (frame_raw == prev_reg) begin
          match_next = (match_reg == MATCH_MAX) ? match_reg : match_reg + MATCH_W'(1);
        end else begin
          match_next = MATCH_W'(1);
        end
        if (match_next == MATCH_MAX && frame_raw != stable_reg) begin
          stable_next = frame_raw;
          if (frame_raw.kind == FR_KEY) begin
            event_next = 1'b1;
          end
        end
      end
`ifdef KEYPAD_REPEAT_EN
      if (stable_next != stable_reg) begin
        rep_next = (stable_next.kind == FR_KEY) ? 16'(REPEAT_DELAY) : '0;
      end else if (stable_reg.kind == FR_KEY && rep_reg != '0) begin
        if (rep_reg == 16'd1) begin
          event_next = 1'b1;
          rep_next   = 16'(REPEAT_RATE);
        end else begin
          rep_next = rep_reg - 16'd1;
        end
      end
`endif
    end
  end

  assign key_held    = (stable_reg.kind == FR_KEY);
  assign event_valid = event_reg;
  // The event pulses in the same cycle stable is updated, so the stable
  // code is always the event code.
  assign event_code  = stable_reg.code;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
// Scan controller for a 4x4 keypad: drives one-cold column strobes on a
// fixed schedule, samples the synchronised rows once per column, classifies
// each frame, debounces it and presents key-press events on a valid/ready
// output register.
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   row[3:0]     keypad rows, active low, asynchronous to clk
//   col[3:0]     column strobes, one-cold
//   key_code     code of the pending event (stable while key_valid)
//   key_valid    event pending
//   key_ready    consumer accepts the pending event
//   key_held     debounced "exactly one key is down"
//   key_overrun  one-cycle pulse: an event was dropped (output full)
// Macro: KEYPAD_REPEAT_EN enables auto-repeat (REPEAT_DELAY, REPEAT_RATE,
// both in frames).
// -----------------------------------------------------------------------------
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int COL_PERIOD      = 100000,
  parameter int SAMPLE_AT       = 8,
  parameter int DEBOUNCE_FRAMES = 3
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_held,
  output logic             key_overrun
);

  localparam int CNT_W = $clog2(COL_PERIOD);

  // ---------------- row synchroniser ----------------
  // Reset to all-ones (no key) so a freshly reset scanner sees an idle pad.
  logic [3:0] row_meta_reg, row_sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
    end else begin
      row_meta_reg <= row;
      row_sync_reg <= row_meta_reg;
    end
  end

  // ---------------- column scanner ----------------
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       col_idx_reg;
  logic             sample_en;
  logic             eval_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      col_idx_reg <= 2'd0;
    end else if (cnt_reg == CNT_W'(COL_PERIOD - 1)) begin
      cnt_reg     <= '0;
      col_idx_reg <= col_idx_reg + 2'd1;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign col       = COL_PATTERN[col_idx_reg];
  // SAMPLE_AT >= 3 leaves time for the 2-flop synchroniser to catch up
  // with the new column.
  assign sample_en = (cnt_reg == CNT_W'(SAMPLE_AT));

  // Frame is evaluated the cycle after the last column's sample lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eval_reg <= 1'b0;
    end else begin
      eval_reg <= sample_en && (col_idx_reg == 2'd3);
    end
  end

  // ---------------- per-column row slots ----------------
  logic [3:0]   slot_reg [4];
  slot_decode_t slot_dec [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          slot_reg[gi] <= 4'hF;
        end else if (sample_en && col_idx_reg == 2'(gi)) begin
          slot_reg[gi] <= row_sync_reg;
        end
      end
      assign slot_dec[gi] = decode_row(slot_reg[gi]);
    end
  endgenerate

  // ---------------- frame classification ----------------
  frame_result_t frame_raw;
  logic [2:0]    n_single;
  logic          any_multi;
  logic [1:0]    key_col;
  logic [1:0]    key_row;

  always_comb begin
    n_single  = 3'd0;
    any_multi = 1'b0;
    key_col   = 2'd0;
    key_row   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (slot_dec[i].single) begin
        n_single = n_single + 3'd1;
        key_col  = 2'(i);
        key_row  = slot_dec[i].row_idx;
      end else if (!slot_dec[i].idle) begin
        any_multi = 1'b1;
      end
    end
    frame_raw = '{kind: FR_NONE, code: '0};
    if (any_multi || n_single > 3'd1) begin
      frame_raw.kind = FR_MULTI;
    end else if (n_single == 3'd1) begin
      frame_raw.kind = FR_KEY;
      frame_raw.code = KEY_MAP[key_col][key_row];
    end
  end

  // ---------------- debounce ----------------
  logic             event_valid;
  logic [KEY_W-1:0] event_code;

  keypad_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_RATE     (REPEAT_RATE)
`endif
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .frame_valid (eval_reg),
    .frame_raw   (frame_raw),
    .key_held    (key_held),
    .event_valid (event_valid),
    .event_code  (event_code)
  );

  // ---------------- output register ----------------
  logic [KEY_W-1:0] key_code_reg, key_code_next;
  logic             key_valid_reg, key_valid_next;
  logic             key_overrun_reg, key_overrun_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code_reg    <= '0;
      key_valid_reg   <= 1'b0;
      key_overrun_reg <= 1'b0;
    end else begin
      key_code_reg    <= key_code_next;
      key_valid_reg   <= key_valid_next;
      key_overrun_reg <= key_overrun_next;
    end
  end

  always_comb begin
    key_code_next    = key_code_reg;
    key_valid_next   = key_valid_reg;
    key_overrun_next = 1'b0;
    if (event_valid) begin
      // A slot frees up in the same cycle it is consumed, so a new event
      // can be taken back-to-back with a handshake.
      if (!key_valid_reg || key_ready) begin
        key_valid_next = 1'b1;
        key_code_next  = event_code;
      end else begin
        key_overrun_next = 1'b1;
      end
    end else if (key_valid_reg && key_ready) begin
      key_valid_next = 1'b0;
    end
  end

  assign key_code    = key_code_reg;
  assign key_valid   = key_valid_reg;
  assign key_overrun = key_overrun_reg;

endmodule
